corr_frame_serializer: RTL and testbench
========================================

# corr_frame_serializer

Downstream framing stage for the correlator snapshot. On each integration strobe it captures the packed counter/correlator word vector into a double buffer. It serializes the captured vector into a headered, sequence-numbered byte frame and hands bytes one at a time to the UART byte transmitter over a valid/ready handshake. A new snapshot can arrive while a frame is still being sent; it waits in the pending buffer and is sent next.

## Interface
Parameters:
- RESOLUTION, 12, bits per counter word.
- NUM_WORDS, 36, words per snapshot (8 inputs + 28 correlators).
- HDR0, 8'hA5, first sync byte.
- HDR1, 8'h5A, second sync byte.
- BYTES_PER_WORD, derived = (RESOLUTION+7)/8, bytes emitted per word.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- snap_data  in  RESOLUTION*NUM_WORDS  packed words; word w = snap_data[w*RESOLUTION +: RESOLUTION].
- snap_strobe  in  1  one-cycle capture pulse (integration clock pulse).
- enable  in  1  when low, strobes are ignored; a frame in progress still completes.
- byte_data  out  8  current frame byte.
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  consumer accepts; a transfer occurs on a cycle with valid && ready.
- busy  out  1  FSM not in IDLE.
- overrun_count  out  8  saturating count of pending-buffer overwrites.

## Operation
- Buffers: active buffer (the one being sent) and pending buffer with pending_valid.
- Capture: snap_strobe && enable at a clock edge loads snap_data into pending and sets pending_valid. If pending_valid was already set, pending is overwritten and overrun_count increments, saturating at 255.
- FSM states: IDLE -> HDR0 -> HDR1 -> SEQ -> PAYLOAD -> (CSUM) -> IDLE.
  - IDLE: if pending_valid, copy pending into active, clear pending_valid, go to HDR0. A capture in the same cycle as promotion keeps pending_valid set with the new data.
  - HDR0 and HDR1 emit the sync bytes.
  - SEQ emits the frame sequence number, then increments it (mod 256).
  - PAYLOAD emits words 0..NUM_WORDS-1. Each word is sent in BYTES_PER_WORD bytes, least-significant byte first. Unused upper bits are zero.
  - CSUM: see Configuration.
- A state advances only on a handshake. Back-pressure (ready low) holds byte_data and byte_valid stable indefinitely.
- After the last byte is accepted, the FSM always spends one cycle in IDLE.
- Default frame length: 3 + 72 (+1) = 75 (76) bytes.
- Byte/word indices are counters; both reset to 0 on entering HDR0.

## Timing
- Reset values (applied on the first posedge with reset_n low): byte_valid=0, byte_data=0, busy=0, overrun_count=0, sequence=0, pending_valid=0, FSM=IDLE, active buffer=0.
- Reset mid-frame: byte_valid drops on the next edge. The partial frame is abandoned and the pending snapshot is discarded.
- Latency: strobe sampled at edge k while IDLE -> pending_valid at k. Promotion happens at k+1, so byte_valid=1 with HDR0 after edge k+1.
- Strobe in the same cycle as the final handshake: the snapshot is captured at that edge, IDLE at the next edge promotes it, and HDR0 is valid one cycle later.
- Throughput with ready held high: one byte per cycle within a frame, plus one IDLE cycle between frames.
- byte_data, byte_valid and busy are registered outputs with no combinational path from inputs.

## Configuration
- CORR_FRAME_CHECKSUM_EN defined:
  - The CSUM state follows PAYLOAD.
  - Checksum byte = two's-complement negation of the 8-bit modular sum of the SEQ byte and all payload bytes, so SEQ..CSUM sums to 8'h00.
  - The checksum accumulator updates on each SEQ/PAYLOAD handshake and clears on HDR0 entry.
- Not defined: CSUM state and accumulator are absent; PAYLOAD goes directly to IDLE and the frame is one byte shorter.

## Test plan
- Single snapshot, ready=1, words w = w+1 (12-bit) -> bytes A5 5A 00 01 00 02 00 … 24 00. With the macro on, the last byte makes the SEQ..CSUM sum 00. HDR0 valid 2 cycles after the strobe; busy low after the last byte.
- Back-pressure: ready toggled 1/0 randomly -> byte stream identical to the ready=1 case; byte_data is stable whenever valid && !ready.
- Overrun: three strobes (data patterns P1, P2, P3) during frame P1 -> frames P1 then P3 only; overrun_count=1; frame SEQ bytes 00 and 01.
- enable=0 with strobes -> no frame, busy stays 0. enable dropped mid-frame -> the current frame completes in full.
- reset_n low mid-PAYLOAD -> byte_valid=0 and overrun_count=0 next edge. Next strobe produces a frame with SEQ=00.
- 256 frames back-to-back -> SEQ wraps FF -> 00; the strobe coincident with the final handshake is sent with no loss.

Source files
------------

// File: rtl/corr_frame_serializer.sv
// corr_frame_serializer
// Captures correlator snapshots into a pending/active double buffer and
// serializes the active buffer as a byte frame:
//     HDR0, HDR1, SEQ, payload words (LSB first) [, CSUM]
// The frame is handed out one byte at a time over a valid/ready handshake.
// Optional feature macro: CORR_FRAME_CHECKSUM_EN adds a trailing checksum
// byte so that the bytes from SEQ through CSUM sum to 8'h00 (mod 256).
module corr_frame_serializer #(
    parameter int          RESOLUTION = 12,
    parameter int          NUM_WORDS  = 36,
    parameter logic [7:0]  HDR0       = 8'hA5,
    parameter logic [7:0]  HDR1       = 8'h5A
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [RESOLUTION*NUM_WORDS-1:0] snap_data,
    input  logic                            snap_strobe,
    input  logic                            enable,
    output logic [7:0]                      byte_data,
    output logic                            byte_valid,
    input  logic                            byte_ready,
    output logic                            busy,
    output logic [7:0]                      overrun_count
);

    localparam int BYTES_PER_WORD = (RESOLUTION + 7) / 8;
    localparam int DATA_W         = RESOLUTION * NUM_WORDS;
    localparam int EXT_W          = BYTES_PER_WORD * 8;
    localparam int WORD_IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BYTE_IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(NUM_WORDS - 1);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_SEQ     = 3'd3,
        ST_PAYLOAD = 3'd4
`ifdef CORR_FRAME_CHECKSUM_EN
        ,
        ST_CSUM    = 3'd5
`endif
    } state_t;

    // Select one byte of a word, zero-extending the unused upper bits.
    function automatic logic [7:0] word_byte(input logic [RESOLUTION-1:0] word,
                                             input logic [BYTE_IDX_W-1:0] sel);
        logic [EXT_W-1:0] ext;
        ext                 = '0;
        ext[RESOLUTION-1:0] = word;
        return ext[int'(sel)*8 +: 8];
    endfunction

`ifdef CORR_FRAME_CHECKSUM_EN
    // Byte that brings the running modular sum back to zero.
    function automatic logic [7:0] csum_byte(input logic [7:0] acc);
        return 8'h00 - acc;
    endfunction
`endif

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       pending_q, pending_d;
    logic                    pending_valid_q, pending_valid_d;
    logic [DATA_W-1:0]       active_q, active_d;
    logic [WORD_IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              overrun_q, overrun_d;
    logic [7:0]              byte_data_q, byte_data_d;
    logic                    byte_valid_q, byte_valid_d;
    logic                    busy_q, busy_d;
`ifdef CORR_FRAME_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic                    handshake_s;
    logic                    capture_s;
    logic                    promote_s;
    logic                    last_byte_s;
    logic [RESOLUTION-1:0]   cur_word_s;

    assign handshake_s   = byte_valid_q && byte_ready;
    assign capture_s     = snap_strobe && enable;
    assign promote_s     = (state_q == ST_IDLE) && pending_valid_q;
    assign last_byte_s   = (word_idx_q == LAST_WORD) && (byte_idx_q == LAST_BYTE);

    assign byte_data     = byte_data_q;
    assign byte_valid    = byte_valid_q;
    assign busy          = busy_q;
    assign overrun_count = overrun_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
            word_idx_q      <= '0;
            byte_idx_q      <= '0;
            seq_q           <= 8'h00;
            overrun_q       <= 8'h00;
            byte_data_q     <= 8'h00;
            byte_valid_q    <= 1'b0;
            busy_q          <= 1'b0;
`ifdef CORR_FRAME_CHECKSUM_EN
            csum_q          <= 8'h00;
`endif
        end else begin
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
            word_idx_q      <= word_idx_d;
            byte_idx_q      <= byte_idx_d;
            seq_q           <= seq_d;
            overrun_q       <= overrun_d;
            byte_data_q     <= byte_data_d;
            byte_valid_q    <= byte_valid_d;
            busy_q          <= busy_d;
`ifdef CORR_FRAME_CHECKSUM_EN
            csum_q          <= csum_d;
`endif
        end
    end

    // Next-state logic: every non-idle state advances only on a handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_valid_q) state_d = ST_HDR0;
                else                 state_d = ST_IDLE;
            end
            ST_HDR0: begin
                if (handshake_s) state_d = ST_HDR1;
                else             state_d = ST_HDR0;
            end
            ST_HDR1: begin
                if (handshake_s) state_d = ST_SEQ;
                else             state_d = ST_HDR1;
            end
            ST_SEQ: begin
                if (handshake_s) state_d = ST_PAYLOAD;
                else             state_d = ST_SEQ;
            end
            ST_PAYLOAD: begin
`ifdef CORR_FRAME_CHECKSUM_EN
                if (handshake_s && last_byte_s) state_d = ST_CSUM;
                else                            state_d = ST_PAYLOAD;
`else
                if (handshake_s && last_byte_s) state_d = ST_IDLE;
                else                            state_d = ST_PAYLOAD;
`endif
            end
`ifdef CORR_FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (handshake_s) state_d = ST_IDLE;
                else             state_d = ST_CSUM;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Buffers, counters, sequence number and overrun bookkeeping.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        active_d        = active_q;
        overrun_d       = overrun_q;
        word_idx_d      = word_idx_q;
        byte_idx_d      = byte_idx_q;
        seq_d           = seq_q;

        // Promotion empties pending; a capture below may refill it at once.
        if (promote_s) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end else begin
            active_d        = active_q;
        end

        // A capture over unsent pending data (not just promoted) is an overrun.
        if (capture_s) begin
            pending_d       = snap_data;
            pending_valid_d = 1'b1;
            if (pending_valid_q && !promote_s && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            pending_d = pending_q;
        end

        // Indices restart while idle so every frame begins at word 0, byte 0.
        if (state_q == ST_IDLE) begin
            word_idx_d = WORD_IDX_W'(0);
            byte_idx_d = BYTE_IDX_W'(0);
        end else if ((state_q == ST_PAYLOAD) && handshake_s && !last_byte_s) begin
            if (byte_idx_q == LAST_BYTE) begin
                byte_idx_d = BYTE_IDX_W'(0);
                word_idx_d = word_idx_q + WORD_IDX_W'(1);
            end else begin
                byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
                word_idx_d = word_idx_q;
            end
        end else begin
            word_idx_d = word_idx_q;
            byte_idx_d = byte_idx_q;
        end

        if ((state_q == ST_SEQ) && handshake_s) begin
            seq_d = seq_q + 8'd1;
        end else begin
            seq_d = seq_q;
        end
    end

`ifdef CORR_FRAME_CHECKSUM_EN
    // Running sum of SEQ and payload bytes; cleared while idle.
    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE) begin
            csum_d = 8'h00;
        end else if (handshake_s && ((state_q == ST_SEQ) || (state_q == ST_PAYLOAD))) begin
            csum_d = csum_q + byte_data_q;
        end else begin
            csum_d = csum_q;
        end
    end
`endif

    // Word of the active buffer addressed by the next word index.
    always_comb begin
        cur_word_s = active_q[int'(word_idx_d)*RESOLUTION +: RESOLUTION];
    end

    // Output register inputs derived from the state being entered.
    always_comb begin
        byte_valid_d = 1'b1;
        busy_d       = 1'b1;
        byte_data_d  = 8'h00;
        case (state_d)
            ST_IDLE: begin
                byte_valid_d = 1'b0;
                busy_d       = 1'b0;
                byte_data_d  = 8'h00;
            end
            ST_HDR0:    byte_data_d = HDR0;
            ST_HDR1:    byte_data_d = HDR1;
            ST_SEQ:     byte_data_d = seq_q;
            ST_PAYLOAD: byte_data_d = word_byte(cur_word_s, byte_idx_d);
`ifdef CORR_FRAME_CHECKSUM_EN
            ST_CSUM:    byte_data_d = csum_byte(csum_d);
`endif
            default: begin
                byte_valid_d = 1'b0;
                busy_d       = 1'b0;
                byte_data_d  = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_corr_frame_serializer.sv
// Directed testbench for corr_frame_serializer (default parameters).
// Builds each expected frame from the snapshot data and compares the
// captured byte stream; also checks latency, back-pressure hold, overrun,
// enable gating, mid-frame reset and sequence wrap with back-to-back frames.
module tb_corr_frame_serializer;

    localparam int RES = 12;
    localparam int NW  = 36;
    localparam int DW  = RES * NW;
`ifdef CORR_FRAME_CHECKSUM_EN
    localparam int LEN = 76;
`else
    localparam int LEN = 75;
`endif

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] snap_data;
    logic          snap_strobe;
    logic          enable;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          busy;
    logic [7:0]    overrun_count;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [7:0]    rx[$];
    bit            hold_pending = 1'b0;
    logic [7:0]    held_byte = 8'h00;

    corr_frame_serializer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .snap_data     (snap_data),
        .snap_strobe   (snap_strobe),
        .enable        (enable),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        snap_data   = d;
        snap_strobe = 1'b1;
        tick();
        snap_strobe = 1'b0;
    endtask

    function automatic logic [DW-1:0] pat_inc();
        logic [DW-1:0] d;
        d = '0;
        for (int w = 0; w < NW; w++) d[w*RES +: RES] = RES'(w + 1);
        return d;
    endfunction

    function automatic logic [DW-1:0] pat(input int seed);
        logic [DW-1:0] d;
        d = '0;
        for (int w = 0; w < NW; w++) d[w*RES +: RES] = RES'(seed * 613 + w * 229 + 91);
        return d;
    endfunction

    function automatic bq_t build_frame(input logic [7:0] seq, input logic [DW-1:0] d);
        bq_t            q;
        logic [7:0]     sum;
        logic [RES-1:0] wv;
        q.push_back(8'hA5);
        q.push_back(8'h5A);
        q.push_back(seq);
        sum = seq;
        for (int w = 0; w < NW; w++) begin
            wv = d[w*RES +: RES];
            q.push_back(wv[7:0]);
            q.push_back({4'h0, wv[11:8]});
            sum = sum + wv[7:0] + {4'h0, wv[11:8]};
        end
`ifdef CORR_FRAME_CHECKSUM_EN
        q.push_back(8'h00 - sum);
`endif
        return q;
    endfunction

    // Count byte differences between the head of rx and an expected frame, then drop that frame.
    task automatic take_frame(input logic [7:0] seq, input logic [DW-1:0] d, output int mism, output int got);
        bq_t exp;
        exp  = build_frame(seq, d);
        mism = 0;
        got  = (rx.size() < LEN) ? rx.size() : LEN;
        for (int i = 0; i < LEN; i++) begin
            if (i >= rx.size()) mism++;
            else if (rx[i] !== exp[i]) mism++;
        end
        for (int i = 0; i < LEN; i++) begin
            if (rx.size() > 0) void'(rx.pop_front());
        end
    endtask

    task automatic cmp_frame(input string tag, input logic [7:0] seq, input logic [DW-1:0] d);
        int mism;
        int got;
        take_frame(seq, d, mism, got);
        chk({tag, "_len"}, got, LEN);
        chk({tag, "_bytes_bad"}, mism, 0);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget, input bit rand_ready);
        int k;
        k = 0;
        while (rx.size() < n && k < budget) begin
            if (rand_ready) byte_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        byte_ready = 1'b1;
        chk({tag, "_in_time"}, (rx.size() >= n) ? 1 : 0, 1);
    endtask

    // Byte collector and back-pressure stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && hold_pending) begin
            chk("hold_valid", byte_valid, 1);
            chk("hold_data", byte_data, held_byte);
        end
        hold_pending = reset_n && byte_valid && !byte_ready;
        held_byte    = byte_data;
        if (reset_n && byte_valid && byte_ready) rx.push_back(byte_data);
    end

    initial begin
        int         mism_total;
        int         timeouts;
        int         cyc0;
        int         mism;
        int         got;
        logic [7:0] wrap_seq;

        reset_n     = 1'b0;
        snap_strobe = 1'b0;
        snap_data   = '0;
        enable      = 1'b1;
        byte_ready  = 1'b1;
        tick();
        tick();
        chk("rst_valid", byte_valid, 0);
        chk("rst_data", byte_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun_count, 8'h00);
        reset_n = 1'b1;
        tick();

        // Single frame, ready high: latency and contents.
        strobe(pat_inc());
        chk("lat_k_valid", byte_valid, 0);
        chk("lat_k_busy", busy, 0);
        tick();
        chk("lat_hdr0_valid", byte_valid, 1);
        chk("lat_hdr0_data", byte_data, 8'hA5);
        chk("lat_hdr0_busy", busy, 1);
        wait_bytes("t1", LEN, 200, 1'b0);
        chk("t1_end_busy", busy, 0);
        chk("t1_end_valid", byte_valid, 0);
        cmp_frame("t1", 8'h00, pat_inc());

        // Random back-pressure.
        strobe(pat(1));
        wait_bytes("t2", LEN, 1500, 1'b1);
        cmp_frame("t2", 8'h01, pat(1));

        // Overrun: P1 sent, P2 overwritten by P3.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        rx.delete();
        strobe(pat(2));
        strobe(pat(3));
        strobe(pat(4));
        chk("ovr_count", overrun_count, 8'h01);
        wait_bytes("t3", 2 * LEN, 400, 1'b0);
        cmp_frame("t3a", 8'h00, pat(2));
        cmp_frame("t3b", 8'h01, pat(4));
        repeat (5) tick();
        chk("t3_idle_busy", busy, 0);
        chk("t3_no_extra", rx.size(), 0);

        // enable low ignores strobes; dropping enable mid-frame completes the frame.
        enable = 1'b0;
        strobe(pat(5));
        repeat (6) tick();
        chk("en0_busy", busy, 0);
        chk("en0_no_bytes", rx.size(), 0);
        chk("en0_overrun", overrun_count, 8'h01);
        enable = 1'b1;
        strobe(pat(6));
        repeat (10) tick();
        enable = 1'b0;
        strobe(pat(7));
        wait_bytes("t4", LEN, 200, 1'b0);
        cmp_frame("t4", 8'h02, pat(6));
        repeat (5) tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_no_extra", rx.size(), 0);
        enable = 1'b1;

        // Reset mid-payload discards the frame and the pending snapshot.
        strobe(pat(8));
        strobe(pat(9));
        strobe(pat(10));
        chk("t5_overrun", overrun_count, 8'h02);
        repeat (15) tick();
        chk("t5_midframe_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        chk("t5_rst_valid", byte_valid, 0);
        chk("t5_rst_overrun", overrun_count, 8'h00);
        chk("t5_rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (5) tick();
        chk("t5_pending_dropped", busy, 0);
        rx.delete();
        strobe(pat(11));
        wait_bytes("t5", LEN, 200, 1'b0);
        cmp_frame("t5", 8'h00, pat(11));

        // 256 back-to-back frames; each next strobe coincides with the final handshake.
        rx.delete();
        mism_total = 0;
        timeouts   = 0;
        wrap_seq   = 8'hFF;
        strobe(pat(100));
        cyc0 = cyc;
        for (int f = 0; f < 256; f++) begin
            int k;
            k = 0;
            while (rx.size() < LEN - 1 && k < 300) begin
                tick();
                k++;
            end
            if (k >= 300) timeouts++;
            if (f < 255) begin
                snap_data   = pat(101 + f);
                snap_strobe = 1'b1;
            end
            tick();
            snap_strobe = 1'b0;
            if (f == 255 && rx.size() > 2) wrap_seq = rx[2];
            take_frame(8'(1 + f), pat(100 + f), mism, got);
            mism_total += mism;
        end
        chk("t6_timeouts", timeouts, 0);
        chk("t6_bytes_bad", mism_total, 0);
        chk("t6_wrap_seq", wrap_seq, 8'h00);
        chk("t6_cycles", cyc - cyc0, 256 * (LEN + 1));
        repeat (3) tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_no_extra", rx.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
